// File: rtl/obi_wrr_scheduler.sv
// Weighted round-robin scheduler sharing one OBI master port among NumReq
// requesters; keeps the A-channel choice stable until granted and routes R beats back in order.
module obi_wrr_scheduler #(
    parameter int unsigned NumReq      = 4,
    parameter int unsigned WeightWidth = 4,
    parameter int unsigned NumMaxTrans = 4,
    parameter int unsigned IdxWidth    = $clog2(NumReq)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_i,
    input  logic [NumReq*WeightWidth-1:0] weight_i,
    output logic [NumReq-1:0]             gnt_o,
    output logic [NumReq-1:0]             rvalid_o,
    output logic [IdxWidth-1:0]           sel_o,
    output logic                          mst_req_o,
    input  logic                          mst_gnt_i,
    input  logic                          mst_rvalid_i,
    output logic [IdxWidth-1:0]           rsp_idx_o,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam int unsigned CntWidth = $clog2(NumMaxTrans + 1);
    localparam int unsigned PtrWidth = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
    localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(NumMaxTrans);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(NumMaxTrans - 1);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                 state_q, state_d;
    logic [IdxWidth-1:0]    owner_q, owner_d;
    logic [WeightWidth-1:0] credit_q, credit_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic [PtrWidth-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic                   err_q, err_d;
    logic [IdxWidth-1:0]    fifo_q [NumMaxTrans];

    logic [WeightWidth-1:0] weights [NumReq];
    logic [WeightWidth-1:0] w_load;
    logic [IdxWidth-1:0]    pick, cand, sel;
    logic                   hit, keep, can_issue, new_pick;
    logic                   mst_req, acc, pop;
    logic [IdxWidth-1:0]    head;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrWidth'(1);
    endfunction

    // Search owner+1 .. owner+NumReq so the current owner is considered last
    always_comb begin
        pick = owner_q;
        cand = owner_q;
        hit  = 1'b0;
        for (int i = 1; i <= int'(NumReq); i++) begin
            cand = IdxWidth'((int'(owner_q) + i) % int'(NumReq));
            if (!hit && req_i[cand]) begin
                hit  = 1'b1;
                pick = cand;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NumReq); i++) begin
            weights[i] = weight_i[i*WeightWidth +: WeightWidth];
        end
    end

    assign keep      = req_i[owner_q] && (credit_q != '0);
    assign can_issue = (|req_i) && (cnt_q < MaxCnt);
    assign new_pick  = (state_q == IDLE) && can_issue && !keep;
    assign w_load    = (weights[pick] == '0) ? WeightWidth'(1) : weights[pick];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mst_req && !mst_gnt_i) state_d = LOCKED;
            LOCKED:  if (mst_gnt_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel     = owner_q;
        mst_req = 1'b0;
        if (state_q == LOCKED) begin
            mst_req = 1'b1;
        end else if (can_issue) begin
            mst_req = 1'b1;
            sel     = keep ? owner_q : pick;
        end
    end

    assign acc  = mst_req && mst_gnt_i;
    assign pop  = mst_rvalid_i && (cnt_q != '0);
    assign head = fifo_q[rptr_q];

    always_comb begin
        owner_d  = owner_q;
        credit_d = credit_q;
        if (new_pick) begin
            owner_d  = pick;
            credit_d = acc ? w_load - WeightWidth'(1) : w_load;
        end else if (acc) begin
            credit_d = credit_q - WeightWidth'(1);
        end
        wptr_d = acc ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        if (acc && !pop)      cnt_d = cnt_q + CntWidth'(1);
        else if (!acc && pop) cnt_d = cnt_q - CntWidth'(1);
        err_d = err_q || (mst_rvalid_i && (cnt_q == '0));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q  <= '0;
            credit_q <= '0;
            cnt_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < int'(NumMaxTrans); i++) fifo_q[i] <= '0;
        end else begin
            owner_q  <= owner_d;
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            err_q    <= err_d;
            if (acc) fifo_q[wptr_q] <= sel;
        end
    end

    // Outputs are forced low while reset is held, even with requests pending
    always_comb begin
        gnt_o     = '0;
        rvalid_o  = '0;
        mst_req_o = mst_req && !rst_i;
        sel_o     = rst_i ? '0 : sel;
        rsp_idx_o = rst_i ? '0 : head;
        if (acc && !rst_i) gnt_o = NumReq'(1) << sel;
        if (pop && !rst_i) rvalid_o = NumReq'(1) << head;
    end

    assign busy_o = (cnt_q != '0);
    assign err_o  = err_q;

endmodule

// File: tb/tb_obi_wrr_scheduler.sv
// Directed testbench for obi_wrr_scheduler with default parameters
// (4 requesters, 4-bit weights, 4 outstanding transactions).
module tb_obi_wrr_scheduler;

    logic       clk, rst;
    logic [3:0] req;
    logic [15:0] weight;
    logic [3:0] gnt, rvalid;
    logic [1:0] sel, rsp_idx;
    logic       mreq, mgnt, mrv, busy, err;

    int n_cmp = 0;
    int n_err = 0;
    logic [1:0] seq [10];

    obi_wrr_scheduler dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .weight_i(weight),
        .gnt_o(gnt), .rvalid_o(rvalid), .sel_o(sel),
        .mst_req_o(mreq), .mst_gnt_i(mgnt), .mst_rvalid_i(mrv),
        .rsp_idx_o(rsp_idx), .busy_o(busy), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; mgnt = 1'b0; mrv = 1'b0;
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; mgnt = 1'b1; mrv = 1'b1;
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        #2;
        n_cmp++; if (gnt !== 4'b0) begin n_err++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        n_cmp++; if (mreq !== 1'b0) begin n_err++; $display("FAIL reset_mreq got %b want 0", mreq); end
        n_cmp++; if (rvalid !== 4'b0) begin n_err++; $display("FAIL reset_rvalid got %b want 0000", rvalid); end
        n_cmp++; if ({sel, rsp_idx, busy, err} !== 6'b0) begin
            n_err++; $display("FAIL reset_misc got %b want 000000", {sel, rsp_idx, busy, err});
        end
        step();
        req = '0; mgnt = 1'b0; mrv = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        weight = {4'd1, 4'd1, 4'd2, 4'd1};
        req = 4'b0010; mgnt = 1'b1; mrv = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) mrv = 1'b1;
            #1;
            n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL single_gnt[%0d] got %b want 0010", k, gnt); end
            n_cmp++; if (sel !== 2'd1) begin n_err++; $display("FAIL single_sel[%0d] got %0d want 1", k, sel); end
            step();
        end
        req = '0; mrv = 1'b1;
        #1;
        n_cmp++; if (rvalid !== 4'b0010) begin n_err++; $display("FAIL single_drain got %b want 0010", rvalid); end
        step();
        mrv = 1'b0; mgnt = 1'b0;
        n_cmp++; if ({busy, err} !== 2'b00) begin n_err++; $display("FAIL single_idle got %b want 00", {busy, err}); end
    endtask

    task automatic test_fairness();
        do_reset();
        seq = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
        weight = {4'd4, 4'd3, 4'd2, 4'd1};
        req = 4'b1111; mgnt = 1'b1; mrv = 1'b0;
        for (int k = 0; k < 20; k++) begin
            mrv = (k > 0);
            #1;
            n_cmp++; if (gnt !== (4'(1) << seq[k % 10])) begin
                n_err++; $display("FAIL fair_gnt[%0d] got %b want %b", k, gnt, 4'(1) << seq[k % 10]);
            end
            if (k > 0) begin
                n_cmp++; if (rvalid !== (4'(1) << seq[(k - 1) % 10])) begin
                    n_err++; $display("FAIL fair_rvalid[%0d] got %b want %b", k, rvalid, 4'(1) << seq[(k - 1) % 10]);
                end
            end
            step();
        end
        req = '0; mrv = 1'b1;
        #1;
        n_cmp++; if (rvalid !== 4'b0001) begin n_err++; $display("FAIL fair_drain got %b want 0001", rvalid); end
        step();
        mrv = 1'b0; mgnt = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fair_busy got %b want 0", busy); end
    endtask

    task automatic test_lock();
        do_reset();
        mgnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req = (k == 0) ? 4'b0001 : (k == 1) ? 4'b0011 : 4'b0010;
            #1;
            n_cmp++; if ({mreq, sel, gnt} !== 7'b1_00_0000) begin
                n_err++; $display("FAIL lock_hold[%0d] got %b want 1000000", k, {mreq, sel, gnt});
            end
            step();
        end
        req = 4'b0011; mgnt = 1'b1;
        #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL lock_gnt got %b want 0001", gnt); end
        step();
        #1;
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL lock_rotate got %b want 0010", gnt); end
        step();
        req = '0; mrv = 1'b1;
        #1;
        n_cmp++; if (rvalid !== 4'b0001) begin n_err++; $display("FAIL lock_rsp0 got %b want 0001", rvalid); end
        step();
        #1;
        n_cmp++; if (rvalid !== 4'b0010) begin n_err++; $display("FAIL lock_rsp1 got %b want 0010", rvalid); end
        step();
        mrv = 1'b0; mgnt = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL lock_busy got %b want 0", busy); end
    endtask

    task automatic test_limit();
        do_reset();
        req = 4'b0100; mgnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL limit_acc[%0d] got %b want 0100", k, gnt); end
            step();
        end
        #1;
        n_cmp++; if ({mreq, gnt, busy} !== 6'b0_0000_1) begin
            n_err++; $display("FAIL limit_block got %b want 000001", {mreq, gnt, busy});
        end
        step();
        mrv = 1'b1;
        #1;
        n_cmp++; if ({mreq, rvalid} !== 5'b0_0100) begin
            n_err++; $display("FAIL limit_nobypass got %b want 00100", {mreq, rvalid});
        end
        step();
        mrv = 1'b0;
        #1;
        n_cmp++; if ({mreq, gnt} !== 5'b1_0100) begin
            n_err++; $display("FAIL limit_release got %b want 10100", {mreq, gnt});
        end
        step();
        req = '0; mrv = 1'b1;
        for (int k = 0; k < 4; k++) step();
        mrv = 1'b0; mgnt = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL limit_drain got %b want 0", busy); end
    endtask

    task automatic test_routing();
        do_reset();
        mgnt = 1'b1;
        req = 4'b0100; #1;
        n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL route_acc2 got %b want 0100", gnt); end
        step();
        req = 4'b0001; #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL route_acc0 got %b want 0001", gnt); end
        step();
        req = 4'b1000; #1;
        n_cmp++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL route_acc3 got %b want 1000", gnt); end
        step();
        req = '0; mrv = 1'b1; #1;
        n_cmp++; if ({rsp_idx, rvalid} !== 6'b10_0100) begin
            n_err++; $display("FAIL route_rsp2 got %b want 100100", {rsp_idx, rvalid});
        end
        step();
        req = 4'b0010; #1;
        n_cmp++; if ({gnt, rvalid} !== 8'b0010_0001) begin
            n_err++; $display("FAIL route_accrsp got %b want 00100001", {gnt, rvalid});
        end
        step();
        req = '0; #1;
        n_cmp++; if (rvalid !== 4'b1000) begin n_err++; $display("FAIL route_rsp3 got %b want 1000", rvalid); end
        step();
        #1;
        n_cmp++; if ({busy, rvalid} !== 5'b1_0010) begin
            n_err++; $display("FAIL route_rsp1 got %b want 10010", {busy, rvalid});
        end
        step();
        mrv = 1'b0; mgnt = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL route_empty got %b want 0", busy); end
    endtask

    task automatic test_error_reset();
        do_reset();
        mrv = 1'b1; #1;
        n_cmp++; if (rvalid !== 4'b0) begin n_err++; $display("FAIL err_rvalid got %b want 0000", rvalid); end
        step();
        mrv = 1'b0;
        n_cmp++; if ({err, busy} !== 2'b10) begin n_err++; $display("FAIL err_set got %b want 10", {err, busy}); end
        step();
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky got %b want 1", err); end
        req = 4'b0001; mgnt = 1'b0;
        step();
        n_cmp++; if (mreq !== 1'b1) begin n_err++; $display("FAIL err_locked got %b want 1", mreq); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if ({mreq, sel, gnt, rvalid, busy, err} !== 13'b0) begin
            n_err++; $display("FAIL async_reset got %b want 0", {mreq, sel, gnt, rvalid, busy, err});
        end
        step();
        req = '0; rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; mgnt = 1'b0; mrv = 1'b0; weight = '0;
        test_reset();
        test_single();
        test_fairness();
        test_lock();
        test_limit();
        test_routing();
        test_error_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
